// File: rtl/filt_scheduler.sv
// Sample sequencer between the XADC stream and the FIR filter engine: buffers samples,
// issues one filter job per sample, returns each result as a one-cycle strobe.
module filt_scheduler #(
    parameter int XADC_DATA_SIZE = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adc_valid,
    input  logic [XADC_DATA_SIZE-1:0] adc_data,
    input  logic [1:0]                cfg_select,
    input  logic                      err_clr,
    output logic                      filt_start,
    output logic [1:0]                filt_select,
    output logic [XADC_DATA_SIZE-1:0] input_val,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    input  logic                      filt_done,
    output logic                      out_valid,
    output logic [XADC_DATA_SIZE-1:0] out_data,
    output logic [1:0]                out_select,
    output logic                      busy,
    output logic                      ovf,
    output logic                      err_timeout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SC_W  = $clog2(START_CYCLES + 1);
    localparam int WD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                    state_r;
    logic [XADC_DATA_SIZE-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic [CNT_W-1:0]          count_nxt_s;
    logic [SC_W-1:0]           start_cnt_r;
    logic [WD_W-1:0]           wd_cnt_r;
    logic                      done_q_r;
    logic                      done_seen_r;
    logic                      filt_start_r;
    logic [1:0]                filt_select_r;
    logic [XADC_DATA_SIZE-1:0] input_val_r;
    logic                      out_valid_r;
    logic [XADC_DATA_SIZE-1:0] out_data_r;
    logic [1:0]                out_select_r;
    logic                      busy_r;
    logic                      ovf_r;
    logic                      err_timeout_r;

    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic done_rise_s;
    logic done_hit_s;
    logic abort_s;
    logic busy_nxt_s;

    assign empty_s     = (count_r == CNT_W'(0));
    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign pop_s       = (state_r == ST_IDLE) && !empty_s;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push_s      = adc_valid && (!full_s || pop_s);
    assign drop_s      = adc_valid && full_s && !pop_s;
    assign done_rise_s = filt_done && !done_q_r;
    assign done_hit_s  = done_seen_r || done_rise_s;
    // The watchdog fires on the clock its count would reach TIMEOUT.
    assign abort_s     = (state_r == ST_WAIT) && !done_hit_s && (wd_cnt_r == WD_W'(TIMEOUT - 1));
    assign busy_nxt_s  = pop_s || (state_r == ST_START) || ((state_r == ST_WAIT) && !abort_s)
                         || (count_nxt_s != CNT_W'(0));

    // Next FIFO occupancy from this cycle's push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Sample FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= adc_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Sticky error flags, done edge history and busy status.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r         <= 1'b0;
            err_timeout_r <= 1'b0;
            done_q_r      <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            done_q_r <= filt_done;
            busy_r   <= busy_nxt_s;
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (err_clr) begin
                ovf_r <= 1'b0;
            end
            if (abort_s) begin
                err_timeout_r <= 1'b1;
            end else if (err_clr) begin
                err_timeout_r <= 1'b0;
            end
        end
    end

    // Job sequencer with registered filter and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            filt_start_r  <= 1'b0;
            filt_select_r <= 2'b00;
            input_val_r   <= XADC_DATA_SIZE'(0);
            out_valid_r   <= 1'b0;
            out_data_r    <= XADC_DATA_SIZE'(0);
            out_select_r  <= 2'b00;
            start_cnt_r   <= SC_W'(0);
            wd_cnt_r      <= WD_W'(0);
            done_seen_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    out_valid_r <= 1'b0;
                    if (pop_s) begin
                        input_val_r   <= mem_r[rd_ptr_r];
                        filt_select_r <= cfg_select;
                        out_select_r  <= cfg_select;
                        if (cfg_select == 2'b11) begin
                            out_data_r  <= mem_r[rd_ptr_r];
                            out_valid_r <= 1'b1;
                            state_r     <= ST_OUT;
                        end else begin
                            filt_start_r <= 1'b1;
                            start_cnt_r  <= SC_W'(0);
                            done_seen_r  <= 1'b0;
                            state_r      <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    if (done_rise_s) begin
                        done_seen_r <= 1'b1;
                    end
                    if (start_cnt_r == SC_W'(START_CYCLES - 1)) begin
                        filt_start_r <= 1'b0;
                        wd_cnt_r     <= WD_W'(0);
                        state_r      <= ST_WAIT;
                    end else begin
                        start_cnt_r <= start_cnt_r + SC_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (done_hit_s) begin
                        out_data_r  <= filt_result;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_OUT;
                    end else if (abort_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                    end
                end
                ST_OUT: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    filt_start_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign filt_start  = filt_start_r;
    assign filt_select = filt_select_r;
    assign input_val   = input_val_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_select  = out_select_r;
    assign busy        = busy_r;
    assign ovf         = ovf_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_filt_scheduler.sv
// Bench for filt_scheduler: a job-timeline reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_filt_scheduler;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int SC    = 2;
    localparam int TO    = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         adc_valid = 1'b0;
    logic [W-1:0] adc_data = '0;
    logic [1:0]   cfg_select = 2'b00;
    logic         err_clr = 1'b0;
    logic         filt_start;
    logic [1:0]   filt_select;
    logic [W-1:0] input_val;
    logic [W-1:0] filt_result = '0;
    logic         filt_done = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_select;
    logic         busy, ovf, err_timeout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    filt_scheduler #(.XADC_DATA_SIZE(W), .FIFO_DEPTH(DEPTH), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data),
        .cfg_select(cfg_select), .err_clr(err_clr), .filt_start(filt_start),
        .filt_select(filt_select), .input_val(input_val), .filt_result(filt_result),
        .filt_done(filt_done), .out_valid(out_valid), .out_data(out_data),
        .out_select(out_select), .busy(busy), .ovf(ovf), .err_timeout(err_timeout)
    );

    // Filter responder: drops done on a start pulse, raises it resp_delay clocks later.
    int           resp_delay = 10;
    bit           resp_stall = 1'b0;
    bit           resp_fixed = 1'b0;
    logic [W-1:0] resp_val = '0;
    bit           force_done = 1'b0;
    int           resp_cnt = -1;
    logic         fs_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) resp_cnt = -1;
        else if (filt_start && !fs_prev) begin
            filt_done = 1'b0;
            resp_cnt = resp_stall ? -1 : resp_delay;
        end else if (resp_cnt > 0) resp_cnt--;
        if (resp_cnt == 0) begin
            filt_done = 1'b1;
            filt_result = resp_fixed ? resp_val : input_val + 16'd7;
            resp_cnt = -1;
        end
        if (force_done) filt_done = 1'b1;
        fs_prev = filt_start;
    end

    // Reference model: a queue of samples plus one job timeline (t = clocks since pop).
    logic [W-1:0] m_q[$];
    bit           m_job = 0, m_byp = 0, m_seen = 0, m_emitted = 0, m_done_q = 1;
    int           m_t = 0;
    bit           m_fs = 0, m_ov = 0, m_busy = 0, m_ovf = 0, m_to = 0;
    logic [1:0]   m_fsel = '0, m_os = '0;
    logic [W-1:0] m_in = '0, m_od = '0;
    bit           rise, set_ovf, set_to;
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            m_job = 0; m_byp = 0; m_seen = 0; m_emitted = 0; m_done_q = 1; m_t = 0;
            m_fs = 0; m_ov = 0; m_busy = 0; m_ovf = 0; m_to = 0;
            m_fsel = '0; m_os = '0; m_in = '0; m_od = '0;
        end else begin
            rise = filt_done && !m_done_q;
            m_ov = 0; set_ovf = 0; set_to = 0;
            if (m_job) begin
                m_t++;
                if (m_emitted) m_job = 0;
                else begin
                    if (rise) m_seen = 1;
                    if (m_seen && m_t > SC) begin
                        m_ov = 1; m_od = filt_result; m_emitted = 1;
                    end else if (m_t == SC + TO) begin
                        m_job = 0; set_to = 1;
                    end
                end
            end else if (m_q.size() > 0) begin
                m_in = m_q.pop_front();
                m_fsel = cfg_select; m_os = cfg_select;
                m_job = 1; m_t = 0; m_seen = 0;
                m_byp = (cfg_select == 2'b11);
                m_emitted = m_byp;
                if (m_byp) begin m_ov = 1; m_od = m_in; end
            end
            if (adc_valid) begin
                if (m_q.size() < DEPTH) m_q.push_back(adc_data);
                else set_ovf = 1;
            end
            if (set_ovf) m_ovf = 1; else if (err_clr) m_ovf = 0;
            if (set_to) m_to = 1; else if (err_clr) m_to = 0;
            m_done_q = filt_done;
            m_fs = m_job && !m_byp && (m_t < SC);
            m_busy = m_job || (m_q.size() > 0);
        end
    end

    typedef struct { int c; logic [W-1:0] d; logic [1:0] s; } ev_t;
    ev_t          ev_q[$];
    int           fs_cnt = 0;
    logic [W-1:0] fs_in = '0;
    logic [1:0]   fs_sel = '0;
    int           to_cyc = -1;

    // Per-cycle comparison against the model plus event logging for directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({filt_start, filt_select, input_val, out_valid, out_data, out_select, busy, ovf, err_timeout} !==
                {m_fs, m_fsel, m_in, m_ov, m_od, m_os, m_busy, m_ovf, m_to}) begin
                fails++;
                $display("FAIL model_cmp cyc=%0d got st=%b sel=%h in=%h ov=%b od=%h os=%h busy=%b ovf=%b to=%b expected st=%b sel=%h in=%h ov=%b od=%h os=%h busy=%b ovf=%b to=%b",
                         cyc, filt_start, filt_select, input_val, out_valid, out_data, out_select, busy, ovf, err_timeout,
                         m_fs, m_fsel, m_in, m_ov, m_od, m_os, m_busy, m_ovf, m_to);
            end
            if (out_valid) ev_q.push_back('{cyc, out_data, out_select});
            if (filt_start) begin fs_cnt++; fs_in = input_val; fs_sel = filt_select; end
            if (err_timeout && to_cyc < 0) to_cyc = cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [W-1:0] d);
        adc_valid = 1'b1; adc_data = d;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic wait_ev(input int n, input int budget, input string name);
        for (int i = 0; i < budget && ev_q.size() < n; i++) tick();
        check(name, ev_q.size(), n);
    endtask

    int e0;

    initial begin
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_outputs", {filt_start, filt_select, input_val, out_valid, out_data, out_select, busy, ovf, err_timeout}, 0);

        // Single LPF job, result 567 after 30 clocks
        resp_fixed = 1; resp_val = 16'd567; resp_delay = 30; cfg_select = 2'b00;
        ev_q.delete(); fs_cnt = 0;
        push(16'd1234); e0 = cyc;
        wait_ev(1, 80, "lpf_out_count");
        check("lpf_out_data", ev_q[0].d, 567);
        check("lpf_out_select", ev_q[0].s, 0);
        check("lpf_latency", ev_q[0].c, e0 + 32);
        check("lpf_start_len", fs_cnt, 2);
        check("lpf_input_val", fs_in, 1234);
        check("lpf_filt_select", fs_sel, 0);
        check("lpf_model_pin", m_od, 567);
        repeat (5) tick();
        check("lpf_single_out", ev_q.size(), 1);

        // Bypass
        resp_fixed = 0; cfg_select = 2'b11; ev_q.delete(); fs_cnt = 0;
        push(16'hABCD); e0 = cyc;
        repeat (4) tick();
        check("byp_out_count", ev_q.size(), 1);
        check("byp_latency", ev_q[0].c, e0 + 1);
        check("byp_out_data", ev_q[0].d, 16'hABCD);
        check("byp_out_select", ev_q[0].s, 3);
        check("byp_no_start", fs_cnt, 0);

        // Overflow with the filter stalled
        cfg_select = 2'b00; resp_delay = 50; ev_q.delete();
        push(16'd100);
        repeat (4) tick();
        adc_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin adc_data = 16'(200 + i); tick(); end
        adc_valid = 1'b0;
        tick();
        check("ovf_set", ovf, 1);
        wait_ev(5, 400, "ovf_out_count");
        check("ovf_first_job", ev_q[0].d, 107);
        for (int i = 1; i < 5; i++) check("ovf_order", ev_q[i].d, 206 + i);
        repeat (60) tick();
        check("ovf_dropped", ev_q.size(), 5);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("ovf_clear", ovf, 0);

        // Watchdog timeout then a normal job
        resp_stall = 1; resp_delay = 10; ev_q.delete(); to_cyc = -1;
        push(16'd300); e0 = cyc;
        push(16'd301);
        repeat (5) tick();
        resp_stall = 0;
        for (int i = 0; i < 300 && to_cyc < 0; i++) tick();
        check("to_edge", to_cyc, e0 + 1 + SC + TO);
        check("to_no_out", ev_q.size(), 0);
        wait_ev(1, 80, "to_next_count");
        check("to_next_data", ev_q[0].d, 308);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("to_clear", err_timeout, 0);

        // Select change while the first job waits
        resp_delay = 20; ev_q.delete();
        push(16'd400); push(16'd401); push(16'd402);
        repeat (3) tick();
        cfg_select = 2'b10;
        wait_ev(3, 200, "sel_out_count");
        check("sel_job1", ev_q[0].s, 0);
        check("sel_job2", ev_q[1].s, 2);
        check("sel_job3", ev_q[2].s, 2);
        check("sel_job3_data", ev_q[2].d, 409);

        // Reset in WAIT with a stale done level
        resp_stall = 1; ev_q.delete();
        push(16'd500); push(16'd501);
        repeat (10) tick();
        force_done = 1; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_outputs", {filt_start, filt_select, input_val, out_valid, out_data, out_select, busy, ovf, err_timeout}, 0);
        repeat (20) tick();
        check("rst_no_out", ev_q.size(), 0);
        check("rst_idle", busy, 0);
        force_done = 0; resp_stall = 0; cfg_select = 2'b01;
        push(16'd600);
        wait_ev(1, 60, "rst_next_count");
        check("rst_next_data", ev_q[0].d, 607);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            adc_valid  = ($urandom_range(0, 3) == 0);
            adc_data   = W'($urandom);
            if ($urandom_range(0, 40) == 0) cfg_select = 2'($urandom);
            err_clr    = ($urandom_range(0, 30) == 0);
            resp_delay = $urandom_range(0, 12);
            resp_stall = ($urandom_range(0, 150) == 0);
            rst        = ($urandom_range(0, 700) == 0);
            tick();
        end
        adc_valid = 1'b0; err_clr = 1'b0; rst = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
